// File: rtl/bus_hold_arbiter.sv
// ============================================================================
// Module   : bus_hold_arbiter
// Brief    : Round-robin HOLD/HLDA bus arbiter for the 8088 local bus.
//            Optional tenure limit enabled by macro BUS_HOLD_TENURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_hold_arbiter #(
  parameter int NREQ       = 4,
  parameter int MAX_TENURE = 64,
  parameter int CNT_W      = 7
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] REQ,
  input  logic            HLDA,
  output logic            HOLD,
  output logic [NREQ-1:0] GNT,
  output logic            BUSY,
  output logic            PREEMPT,
  output logic            ERR
);

  localparam int c_PW = $clog2(NREQ);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_HOLD_REQ = 2'd1;
  localparam logic [1:0] c_GRANTED  = 2'd2;
  localparam logic [1:0] c_RELEASE  = 2'd3;

  if (NREQ < 2 || NREQ > 8 || MAX_TENURE < 1 || (2**CNT_W) <= MAX_TENURE) begin : g_param_check
    $error("bus_hold_arbiter: illegal parameter combination");
  end

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [c_PW-1:0] r_winner;
  logic [c_PW-1:0] r_rr_ptr;
  logic [c_PW-1:0] w_pick;
  logic            w_found;
  logic            w_win_req;
  logic            w_limit;
  logic [NREQ-1:0] w_win_oh;

  logic            r_hold;
  logic [NREQ-1:0] r_gnt;
  logic            r_busy;
  logic            r_preempt;
  logic            r_err;
  logic            w_hold_d;
  logic [NREQ-1:0] w_gnt_d;
  logic            w_busy_d;
  logic            w_preempt_d;
  logic            w_err_d;

  assign w_win_req = REQ[r_winner];
  assign w_win_oh  = {{(NREQ-1){1'b0}}, 1'b1} << r_winner;

  // First set request at or above the pointer, else the lowest set request.
  always_comb begin
    w_pick  = r_rr_ptr;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && REQ[i] && (i >= int'(r_rr_ptr))) begin
        w_pick  = c_PW'(i);
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && REQ[i]) begin
        w_pick  = c_PW'(i);
        w_found = 1'b1;
      end
    end
  end

`ifdef BUS_HOLD_TENURE_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_cnt <= '0;
    end else if (r_state == c_IDLE && |REQ) begin
      r_cnt <= '0;
    end else if (r_state == c_GRANTED && r_cnt != {CNT_W{1'b1}}) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_limit = (r_cnt == CNT_W'(MAX_TENURE - 1));
`else
  assign w_limit = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (|REQ) w_next = c_HOLD_REQ;
      end
      c_HOLD_REQ: begin
        if (HLDA) w_next = w_win_req ? c_GRANTED : c_RELEASE;
      end
      c_GRANTED: begin
        if (!HLDA || !w_win_req || w_limit) w_next = c_RELEASE;
      end
      c_RELEASE: begin
        if (!HLDA) w_next = c_IDLE;
      end
      default: w_next = c_IDLE;
    endcase
  end

  // Output logic: values presented in the state being entered
  always_comb begin
    w_hold_d    = (w_next == c_HOLD_REQ) || (w_next == c_GRANTED);
    w_gnt_d     = (w_next == c_GRANTED) ? w_win_oh : '0;
    w_busy_d    = (w_next != c_IDLE);
    w_preempt_d = (r_state == c_GRANTED) && HLDA && w_win_req && w_limit;
    w_err_d     = r_err || ((r_state == c_GRANTED) && !HLDA);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_hold    <= 1'b0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_hold    <= w_hold_d;
      r_gnt     <= w_gnt_d;
      r_busy    <= w_busy_d;
      r_preempt <= w_preempt_d;
      r_err     <= w_err_d;
    end
  end

  // Winner is frozen for the tenure; pointer moves past it once the CPU reclaims the bus.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_winner <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (r_state == c_IDLE && |REQ) begin
        r_winner <= w_pick;
      end
      if (r_state == c_RELEASE && !HLDA) begin
        r_rr_ptr <= (r_winner == c_PW'(NREQ - 1)) ? '0 : r_winner + 1'b1;
      end
    end
  end

  assign HOLD    = r_hold;
  assign GNT     = r_gnt;
  assign BUSY    = r_busy;
  assign PREEMPT = r_preempt;
  assign ERR     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bus_hold_arbiter.sv
// ============================================================================
// Module   : tb_bus_hold_arbiter
// Brief    : Directed self-checking bench for bus_hold_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_hold_arbiter;

  localparam int NREQ = 4;

  logic            CLK   = 1'b0;
  logic            RESET = 1'b0;
  logic [NREQ-1:0] REQ   = '0;
  logic            HLDA  = 1'b0;
  logic            HOLD;
  logic [NREQ-1:0] GNT;
  logic            BUSY;
  logic            PREEMPT;
  logic            ERR;

  int total = 0;
  int bad   = 0;

  bus_hold_arbiter #(
    .NREQ       (NREQ),
    .MAX_TENURE (8),
    .CNT_W      (7)
  ) u_dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .REQ     (REQ),
    .HLDA    (HLDA),
    .HOLD    (HOLD),
    .GNT     (GNT),
    .BUSY    (BUSY),
    .PREEMPT (PREEMPT),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic hold, input logic [NREQ-1:0] gnt,
                         input logic busy);
    chk({tag, "_hold"}, 32'(HOLD), 32'(hold));
    chk({tag, "_gnt"},  32'(GNT),  32'(gnt));
    chk({tag, "_busy"}, 32'(BUSY), 32'(busy));
  endtask

  task automatic wait_hold(input string tag);
    int n;
    n = 0;
    while (HOLD !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_hold_seen"}, 32'(HOLD), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] rr_exp [5];
    int run, pre;
    logic broken, last_gnt;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // Reset then idle
    RESET = 1'b0; REQ = '0; HLDA = 1'b0;
    tick(); chk_out("rst1", 0, 4'b0000, 0);
    chk("rst1_err", 32'(ERR), 0); chk("rst1_pre", 32'(PREEMPT), 0);
    tick(); chk_out("rst2", 0, 4'b0000, 0);
    RESET = 1'b1;
    tick(); chk_out("idle", 0, 4'b0000, 0);
    chk("idle_err", 32'(ERR), 0);

    // Single requester, HLDA 3 cycles after HOLD, 10 granted cycles
    REQ = 4'b0100;
    tick(); chk_out("t2_hreq", 1, 4'b0000, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out("t2_wait", 1, 4'b0000, 1);
    end
    HLDA = 1'b1;
    tick(); chk_out("t2_gnt", 1, 4'b0100, 1);
    for (int i = 0; i < 9; i++) begin
      tick(); chk("t2_gnt_hold", 32'(GNT), 32'h4);
    end
    REQ = '0;
    tick(); chk_out("t2_rel", 0, 4'b0000, 1);
    HLDA = 1'b0;
    tick(); chk_out("t2_idle", 0, 4'b0000, 0);

    // Pointer now 3: requester 3 beats requester 0
    REQ = 4'b1001;
    tick(); chk("t2p_hold", 32'(HOLD), 1);
    HLDA = 1'b1;
    tick(); chk("t2p_rrptr", 32'(GNT), 32'h8);
    REQ = '0;
    tick(); HLDA = 1'b0;
    tick(); chk_out("t2p_idle", 0, 4'b0000, 0);

    // Round robin with all requesters asserted
    REQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_hold("t3");
      tick(); chk("t3_nogrant_yet", 32'(GNT), 0);
      HLDA = 1'b1;
      tick(); chk("t3_gnt", 32'(GNT), 32'(rr_exp[k]));
      tick(); chk("t3_gnt2", 32'(GNT), 32'(rr_exp[k]));
      REQ = 4'b1111 & ~rr_exp[k];
      tick(); chk_out("t3_rel", 0, 4'b0000, 1);
      HLDA = 1'b0;
      tick(); chk_out("t3_idle", 0, 4'b0000, 0);
      REQ = 4'b1111;
    end
    REQ = '0;
    tick(); chk_out("t3_end", 0, 4'b0000, 0);

    // Withdrawal before HLDA
    REQ = 4'b0010;
    tick(); chk("t4_hold", 32'(HOLD), 1);
    REQ = '0;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_out("t4_wait", 1, 4'b0000, 1);
    end
    HLDA = 1'b1;
    tick(); chk_out("t4_rel", 0, 4'b0000, 1);
    HLDA = 1'b0;
    tick(); chk_out("t4_idle", 0, 4'b0000, 0);

    // Protocol error, sticky ERR, reset mid HOLD_REQ
    REQ = 4'b0100;
    tick(); chk("t5_hold", 32'(HOLD), 1);
    HLDA = 1'b1;
    tick(); chk("t5_gnt", 32'(GNT), 32'h4);
    tick();
    HLDA = 1'b0;
    tick(); chk_out("t5_err_rel", 0, 4'b0000, 1);
    chk("t5_err", 32'(ERR), 1);
    tick(); chk("t5_err_idle", 32'(ERR), 1); chk("t5_idle_busy", 32'(BUSY), 0);
    tick(); chk("t5_rehold", 32'(HOLD), 1); chk("t5_err_sticky", 32'(ERR), 1);
    RESET = 1'b0;
    tick(); chk_out("t5_rst", 0, 4'b0000, 0);
    chk("t5_rst_err", 32'(ERR), 0);
    RESET = 1'b1; REQ = '0;
    tick(); chk_out("t5_idle", 0, 4'b0000, 0);

    // REQ and HLDA fall together during a grant
    REQ = 4'b0001;
    tick(); HLDA = 1'b1;
    tick(); chk("t5b_gnt", 32'(GNT), 32'h1);
    REQ = '0; HLDA = 1'b0;
    tick(); chk_out("t5b_rel", 0, 4'b0000, 1);
    chk("t5b_err", 32'(ERR), 1);
    chk("t5b_pre", 32'(PREEMPT), 0);
    RESET = 1'b0;
    tick(); chk("t5b_rst_err", 32'(ERR), 0);
    RESET = 1'b1;
    tick();

    // Tenure limit (feature) or unlimited grant (default)
    REQ = 4'b0001;
    tick(); HLDA = 1'b1;
    tick();
    run = 0; pre = 0; broken = 1'b0; last_gnt = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (GNT == 4'b0001 && !broken) run++;
      else broken = 1'b1;
      if (PREEMPT) pre++;
      last_gnt = GNT[0];
      HLDA = HOLD;
      tick();
    end
`ifdef BUS_HOLD_TENURE_EN
    chk("t6_run", 32'(run), 8);
    chk("t6_preempt", 32'(pre), 1);
`else
    chk("t6_run", 32'(run), 14);
    chk("t6_preempt", 32'(pre), 0);
`endif
    chk("t6_regrant", 32'(last_gnt), 1);
    chk("t6_err", 32'(ERR), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
